// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready flow control,
// synchronous flush, bubble masking of control bits and an optional
// two-entry skid buffer. The capture edge is selectable so the block can
// replace the existing falling-edge stage registers directly.
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 3,
  parameter int SKID     = 1,
  parameter int NEG_EDGE = 1
) (
  input  logic              clk_PipeReg,
  input  logic              rst_n_PipeReg,
  input  logic              flush_PipeReg,
  input  logic              in_valid_PipeReg,
  output logic              in_ready_PipeReg,
  input  logic [DATA_W-1:0] in_data_PipeReg,
  input  logic [CTRL_W-1:0] in_ctrl_PipeReg,
  output logic              out_valid_PipeReg,
  input  logic              out_ready_PipeReg,
  output logic [DATA_W-1:0] out_data_PipeReg,
  output logic [CTRL_W-1:0] out_ctrl_PipeReg,
  output logic [1:0]        occupancy_PipeReg
);

  // M is the head entry driving the outputs; S is the skid entry (SKID=1 only).
  typedef struct packed {
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
  } stage_t;

  stage_t st_q;
  stage_t st_d;
  logic   accept;
  logic   release_head;

  // With the skid buffer, in_ready depends only on registered S.valid and flush,
  // so it never forms a combinational path from out_ready.
  always_comb begin
    if (SKID != 0)
      in_ready_PipeReg = !st_q.s_valid && !flush_PipeReg;
    else
      in_ready_PipeReg = (!st_q.m_valid || out_ready_PipeReg) && !flush_PipeReg;
  end

  assign accept       = in_valid_PipeReg && in_ready_PipeReg;
  assign release_head = st_q.m_valid && out_ready_PipeReg && !flush_PipeReg;

  // Next-state: flush first, then release/accept movement between M and S.
  always_comb begin
    st_d = st_q;
    if (flush_PipeReg) begin
      st_d.m_valid = 1'b0;
      st_d.m_ctrl  = '0;
      st_d.s_valid = 1'b0;
      st_d.s_ctrl  = '0;
    end else if (SKID != 0) begin
      if (release_head) begin
        if (st_q.s_valid) begin
          // S drains into M; accept cannot happen here since in_ready was 0.
          st_d.m_valid = 1'b1;
          st_d.m_data  = st_q.s_data;
          st_d.m_ctrl  = st_q.s_ctrl;
          st_d.s_valid = 1'b0;
          st_d.s_ctrl  = '0;
        end else if (accept) begin
          st_d.m_data  = in_data_PipeReg;
          st_d.m_ctrl  = in_ctrl_PipeReg;
        end else begin
          st_d.m_valid = 1'b0;
        end
      end else if (accept) begin
        if (!st_q.m_valid) begin
          st_d.m_valid = 1'b1;
          st_d.m_data  = in_data_PipeReg;
          st_d.m_ctrl  = in_ctrl_PipeReg;
        end else begin
          st_d.s_valid = 1'b1;
          st_d.s_data  = in_data_PipeReg;
          st_d.s_ctrl  = in_ctrl_PipeReg;
        end
      end
    end else begin
      if (accept) begin
        st_d.m_valid = 1'b1;
        st_d.m_data  = in_data_PipeReg;
        st_d.m_ctrl  = in_ctrl_PipeReg;
      end else if (release_head) begin
        st_d.m_valid = 1'b0;
      end
    end
  end

  generate
    if (NEG_EDGE != 0) begin : g_neg_edge
      // State register capturing on the falling edge.
      always_ff @(negedge clk_PipeReg or negedge rst_n_PipeReg) begin
        if (!rst_n_PipeReg) st_q <= '0;
        else                st_q <= st_d;
      end
    end else begin : g_pos_edge
      // State register capturing on the rising edge.
      always_ff @(posedge clk_PipeReg or negedge rst_n_PipeReg) begin
        if (!rst_n_PipeReg) st_q <= '0;
        else                st_q <= st_d;
      end
    end
  endgenerate

  // Outputs come straight from M; control is masked so a bubble has no side effect.
  always_comb begin
    out_valid_PipeReg = st_q.m_valid;
    out_data_PipeReg  = st_q.m_data;
    out_ctrl_PipeReg  = st_q.m_ctrl & {CTRL_W{st_q.m_valid}};
    occupancy_PipeReg = {1'b0, st_q.m_valid} + {1'b0, st_q.s_valid};
  end

endmodule
